pe_array_stu_aggregator: RTL

//  Parametrised successor to the PE array's per-PE upstream wiring: merges NUM_PE PE stack-bus-upstream

---
 rtl/pe_array_stu_pkg.sv | 29 ++
 rtl/pe_array_rr_arbiter.sv | 41 ++++
 rtl/pe_array_stu_aggregator.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/pe_array_stu_pkg.sv
// ----------------------------------------------------------------------------
// pe_array_stu_pkg
//   Shared definitions for the PE array stack-bus-upstream aggregator:
//   cntl encodings ({EOM,SOM}), the aggregator FSM state type and small
//   helpers that decode the start/end-of-message bits from a cntl field.
//   MOM is encoded as 2'b00 (neither bit set).
// ----------------------------------------------------------------------------
package pe_array_stu_pkg;

    localparam logic [1:0] CNTL_SOM     = 2'b01;
    localparam logic [1:0] CNTL_EOM     = 2'b10;
    localparam logic [1:0] CNTL_SOM_EOM = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } stu_state_e;

    // True when the beat opens a packet (SOM or SOM_EOM)
    function automatic logic cntl_is_som(input logic [1:0] cntl);
        return (cntl == CNTL_SOM) || (cntl == CNTL_SOM_EOM);
    endfunction

    // True when the beat closes a packet (EOM or SOM_EOM)
    function automatic logic cntl_is_eom(input logic [1:0] cntl);
        return (cntl == CNTL_EOM) || (cntl == CNTL_SOM_EOM);
    endfunction

endpackage

// File: rtl/pe_array_rr_arbiter.sv
// ----------------------------------------------------------------------------
// pe_array_rr_arbiter
//   Combinational round-robin picker: selects the first asserted request at
//   or after the pointer, wrapping from NUM_PE-1 back to 0.
// Ports:
//   req        in   NUM_PE   request vector
//   ptr        in   PEID_W   round-robin start position (< NUM_PE)
//   grant_oh   out  NUM_PE   one-hot grant, zero when no request
//   grant_idx  out  PEID_W   index of the granted request
// ----------------------------------------------------------------------------
module pe_array_rr_arbiter #(
    parameter int NUM_PE = 64,
    parameter int PEID_W = $clog2(NUM_PE)
) (
    input  logic [NUM_PE-1:0] req,
    input  logic [PEID_W-1:0] ptr,
    output logic [NUM_PE-1:0] grant_oh,
    output logic [PEID_W-1:0] grant_idx
);

    localparam logic [PEID_W:0] NUM_PE_EXT = (PEID_W+1)'(NUM_PE);

    logic [NUM_PE-1:0] rotated;
    logic [PEID_W-1:0] offset;
    logic [PEID_W:0]   sum;

    // Rotate the requests so the pointer position lands at bit 0, find the
    // lowest set bit, then add the pointer back modulo NUM_PE.
    always_comb begin
        rotated = NUM_PE'({req, req} >> ptr);
        offset  = '0;
        for (int k = NUM_PE - 1; k >= 0; k--) begin
            if (rotated[k]) offset = PEID_W'(k);
        end
        sum = {1'b0, ptr} + {1'b0, offset};
        if (sum >= NUM_PE_EXT) sum = sum - NUM_PE_EXT;
        grant_idx = sum[PEID_W-1:0];
        grant_oh  = (|req) ? (NUM_PE'(1) << grant_idx) : '0;
    end

endmodule

// File: rtl/pe_array_stu_aggregator.sv
// ----------------------------------------------------------------------------
// pe_array_stu_aggregator
//   Merges NUM_PE PE stack-bus-upstream channels into one upstream port with
//   packet-atomic round-robin arbitration and a 2-entry output skid FIFO.
//   Also registers the array barrier (allSynchronized) and the array-level
//   ready/complete reductions, and flags cntl protocol errors (sticky).
// Ports:
//   clk, reset_poweron               clock, synchronous active-high reset
//   pe__stu__valid/cntl/type/data/oob_data   per-PE upstream beats (packed)
//   stu__pe__ready                   per-PE ready, one-hot or zero
//   array__stu__valid/cntl/type/data/oob_data/peId   merged beat + source PE
//   stu__array__ready                downstream ready
//   pe__sys__thisSynchronized, sys__pe__allSynchronized   barrier in/out
//   pe__sys__ready/complete, array__sys__ready/complete   status in/out
//   array__sys__protocolErr          sticky cntl protocol error
// Optional build macro PE_ARRAY_STU_STATS_EN adds per-PE saturating packet
// counters readable through stats_sel / stats_pktCount.
// ----------------------------------------------------------------------------
module pe_array_stu_aggregator
    import pe_array_stu_pkg::*;
#(
    parameter int NUM_PE = 64,
    parameter int DATA_W = 64,
    parameter int OOB_W  = 32,
    parameter int TYPE_W = 2,
    parameter int CNTL_W = 2,
    parameter int PEID_W = $clog2(NUM_PE)
) (
    input  logic                     clk,
    input  logic                     reset_poweron,
    input  logic [NUM_PE-1:0]        pe__stu__valid,
    input  logic [NUM_PE*CNTL_W-1:0] pe__stu__cntl,
    input  logic [NUM_PE*TYPE_W-1:0] pe__stu__type,
    input  logic [NUM_PE*DATA_W-1:0] pe__stu__data,
    input  logic [NUM_PE*OOB_W-1:0]  pe__stu__oob_data,
    output logic [NUM_PE-1:0]        stu__pe__ready,
    output logic                     array__stu__valid,
    output logic [CNTL_W-1:0]        array__stu__cntl,
    output logic [TYPE_W-1:0]        array__stu__type,
    output logic [DATA_W-1:0]        array__stu__data,
    output logic [OOB_W-1:0]         array__stu__oob_data,
    output logic [PEID_W-1:0]        array__stu__peId,
    input  logic                     stu__array__ready,
    input  logic [NUM_PE-1:0]        pe__sys__thisSynchronized,
    output logic                     sys__pe__allSynchronized,
    input  logic [NUM_PE-1:0]        pe__sys__ready,
    input  logic [NUM_PE-1:0]        pe__sys__complete,
    output logic                     array__sys__ready,
    output logic                     array__sys__complete,
    output logic                     array__sys__protocolErr
`ifdef PE_ARRAY_STU_STATS_EN
    ,
    input  logic [PEID_W-1:0]        stats_sel,
    output logic [15:0]              stats_pktCount
`endif
);

    localparam int ENTRY_W = CNTL_W + TYPE_W + DATA_W + OOB_W + PEID_W;

    stu_state_e        state_q;
    logic [PEID_W-1:0] grant_q;
    logic [PEID_W-1:0] rr_ptr_q;
    logic              mid_pkt_q;
    logic              protocol_err_q;

    logic [ENTRY_W-1:0] skid_mem [2];
    logic               skid_rd_q;
    logic               skid_wr_q;
    logic [1:0]         skid_cnt_q;

    logic [NUM_PE-1:0] eligible;
    logic [NUM_PE-1:0] stray;
    logic [NUM_PE-1:0] arb_grant_oh;
    logic [PEID_W-1:0] arb_grant_idx;
    logic              arb_any;

    logic              sel_valid;
    logic [CNTL_W-1:0] sel_cntl;
    logic [TYPE_W-1:0] sel_type;
    logic [DATA_W-1:0] sel_data;
    logic [OOB_W-1:0]  sel_oob;
    logic              sel_som;
    logic              sel_eom;
    logic              can_accept;
    logic              push;
    logic              pop;
    logic [PEID_W-1:0] grant_next;

    // Classify every PE's current beat: a packet opener makes the PE eligible
    // for arbitration, anything else seen while idle is a protocol error.
    always_comb begin
        eligible = '0;
        stray    = '0;
        for (int i = 0; i < NUM_PE; i++) begin
            eligible[i] = pe__stu__valid[i] &  cntl_is_som(pe__stu__cntl[i*CNTL_W +: 2]);
            stray[i]    = pe__stu__valid[i] & ~cntl_is_som(pe__stu__cntl[i*CNTL_W +: 2]);
        end
    end

    pe_array_rr_arbiter #(
        .NUM_PE (NUM_PE),
        .PEID_W (PEID_W)
    ) u_arbiter (
        .req       (eligible),
        .ptr       (rr_ptr_q),
        .grant_oh  (arb_grant_oh),
        .grant_idx (arb_grant_idx)
    );

    assign arb_any = |arb_grant_oh;

    // Route the granted PE's channel onto the internal beat bus.
    always_comb begin
        sel_valid = 1'b0;
        sel_cntl  = '0;
        sel_type  = '0;
        sel_data  = '0;
        sel_oob   = '0;
        for (int i = 0; i < NUM_PE; i++) begin
            if (grant_q == PEID_W'(i)) begin
                sel_valid = pe__stu__valid[i];
                sel_cntl  = pe__stu__cntl[i*CNTL_W +: CNTL_W];
                sel_type  = pe__stu__type[i*TYPE_W +: TYPE_W];
                sel_data  = pe__stu__data[i*DATA_W +: DATA_W];
                sel_oob   = pe__stu__oob_data[i*OOB_W +: OOB_W];
            end
        end
    end

    assign sel_som    = cntl_is_som(sel_cntl[1:0]);
    assign sel_eom    = cntl_is_eom(sel_cntl[1:0]);
    // Ready comes from the registered count, so a full skid never sees a push.
    assign can_accept = (skid_cnt_q != 2'd2);
    assign push       = (state_q == ST_XFER) && can_accept && sel_valid;
    assign pop        = (skid_cnt_q != 2'd0) && stu__array__ready;
    assign grant_next = (grant_q == PEID_W'(NUM_PE - 1)) ? '0 : grant_q + PEID_W'(1);

    assign stu__pe__ready = ((state_q == ST_XFER) && can_accept) ? (NUM_PE'(1) << grant_q) : '0;

    // Packet-atomic arbitration FSM: IDLE latches a grant (one bubble cycle),
    // XFER streams that PE until an accepted end-of-message beat.
    always_ff @(posedge clk) begin
        if (reset_poweron) begin
            state_q        <= ST_IDLE;
            grant_q        <= '0;
            rr_ptr_q       <= '0;
            mid_pkt_q      <= 1'b0;
            protocol_err_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (|stray) protocol_err_q <= 1'b1;
                    if (arb_any) begin
                        grant_q   <= arb_grant_idx;
                        mid_pkt_q <= 1'b0;
                        state_q   <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (push) begin
                        if (sel_som && mid_pkt_q) protocol_err_q <= 1'b1;
                        if (sel_eom) begin
                            rr_ptr_q  <= grant_next;
                            mid_pkt_q <= 1'b0;
                            state_q   <= ST_IDLE;
                        end else begin
                            mid_pkt_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Two-entry skid FIFO; the output port is driven straight from the head
    // entry, so an accepted beat appears one cycle after its handshake.
    always_ff @(posedge clk) begin
        if (reset_poweron) begin
            skid_rd_q   <= 1'b0;
            skid_wr_q   <= 1'b0;
            skid_cnt_q  <= 2'd0;
            skid_mem[0] <= '0;
            skid_mem[1] <= '0;
        end else begin
            if (push) begin
                skid_mem[skid_wr_q] <= {sel_cntl, sel_type, sel_data, sel_oob, grant_q};
                skid_wr_q           <= ~skid_wr_q;
            end
            if (pop) skid_rd_q <= ~skid_rd_q;
            case ({push, pop})
                2'b10:   skid_cnt_q <= skid_cnt_q + 2'd1;
                2'b01:   skid_cnt_q <= skid_cnt_q - 2'd1;
                default: skid_cnt_q <= skid_cnt_q;
            endcase
        end
    end

    assign array__stu__valid = (skid_cnt_q != 2'd0);
    assign {array__stu__cntl, array__stu__type, array__stu__data,
            array__stu__oob_data, array__stu__peId} = skid_mem[skid_rd_q];
    assign array__sys__protocolErr = protocol_err_q;

    // Array-wide barrier and status reductions, registered for timing.
    always_ff @(posedge clk) begin
        if (reset_poweron) begin
            sys__pe__allSynchronized <= 1'b0;
            array__sys__ready        <= 1'b0;
            array__sys__complete     <= 1'b0;
        end else begin
            sys__pe__allSynchronized <= &pe__sys__thisSynchronized;
            array__sys__ready        <= &pe__sys__ready;
            array__sys__complete     <= &pe__sys__complete;
        end
    end

`ifdef PE_ARRAY_STU_STATS_EN
    logic [15:0] pkt_cnt_q [NUM_PE];

    // Per-PE completed-packet counters, saturating at all ones.
    always_ff @(posedge clk) begin
        if (reset_poweron) begin
            for (int i = 0; i < NUM_PE; i++) pkt_cnt_q[i] <= '0;
            stats_pktCount <= '0;
        end else begin
            if (push && sel_eom && (pkt_cnt_q[grant_q] != 16'hFFFF)) begin
                pkt_cnt_q[grant_q] <= pkt_cnt_q[grant_q] + 16'd1;
            end
            stats_pktCount <= pkt_cnt_q[stats_sel];
        end
    end
`endif

endmodule
